intdiv_seq_ctrl: RTL
====================

// Module: intdiv_seq_ctrl
// PURPOSE
//  Sequencer for the digit-serial SD2 integer divider datapath.
//  - Accepts one operand pair per valid/ready handshake and converts both operands to sign/magnitude.
//  - Streams dividend and divisor MSB-first as SD2 digits. Each magnitude bit maps with the operand sign as: 1,+ -> 01; 1,- -> 11; 0 -> 00.
//  - Collects the N quotient digits returned by the datapath into an N-bit two's-complement quotient.
//  - Sits between the issue logic and the divider datapath.
// PARAMETERS
//  N      16  operand and quotient width in bits (>=4)
//  DELTA  2   datapath online delay: iterations before the first valid q_digit (1..4)
// PORTS
//  clk           in   1  single clock, rising edge
//  rst_n         in   1  asynchronous reset, active low
//  in_valid      in   1  operand pair valid
//  in_ready      out  1  controller idle, can accept an operand pair
//  dividend      in   N  dividend
//  divisor       in   N  divisor
//  is_signed     in   1  1 = operands are two's complement, 0 = unsigned
//  dp_clr        out  1  one-cycle clear of the datapath residual
//  dp_en         out  1  datapath iteration enable
//  x_digit       out  2  SD2 dividend digit (01=+1, 11=-1, 00=0)
//  d_digit       out  2  SD2 divisor digit, same encoding
//  q_digit       in   2  SD2 quotient digit from datapath; 10 is accepted as 0
//  out_valid     out  1  result valid
//  out_ready     in   1  result accepted
//  quotient      out  N  two's-complement quotient
//  div_by_zero   out  1  result was a divide by zero
// BEHAVIOUR
//  Reset values: state=IDLE, in_ready=1, all other outputs 0.
//  FSM states: IDLE -> LOAD -> FEED -> DRAIN -> DONE -> IDLE.
//  - IDLE: in_ready=1. Accept on in_valid&in_ready and latch the magnitudes and signs.
//    * Signed operand with MSB=1: sign=1, magnitude=-operand as N-bit unsigned; -2^(N-1) gives 2^(N-1).
//    * Divisor==0: go straight to DONE with quotient={N{1'b1}}, div_by_zero=1. No dp_clr, no dp_en.
//    * Otherwise go to LOAD.
//  - LOAD (1 cycle): dp_clr=1, dp_en=0, Q cleared, iteration counter i=0.
//  - FEED (N cycles): dp_en=1.
//    * x_digit/d_digit = SD2 of magnitude bit N-1-i of each operand.
//  - DRAIN (DELTA cycles): dp_en=1, x_digit=d_digit=00.
//  - Capture: while dp_en=1 and i>=DELTA, sample q_digit with Q <= (Q<<1) + val(q_digit) mod 2^N.
//    Exactly N digits are captured, MSB first.
//  - DONE: out_valid=1. quotient and div_by_zero are held stable until out_valid&out_ready, then return to IDLE.
//    in_ready=0 in every state except IDLE.
//  Latency: out_valid rises N+DELTA+2 cycles after the accept edge; divide by zero takes 2 cycles.
//  dp_en, dp_clr, x_digit and d_digit are registered. Digits are 00 whenever dp_en=0.
//  Overflow: signed -2^(N-1)/-1 wraps to -2^(N-1). No flag is raised.
//  in_valid outside IDLE is ignored, with no side effects.
//  rst_n low in any state immediately forces reset values. A partial result is discarded.
//  Back-to-back: the DONE handshake and a new accept never occur in the same cycle. Accept happens at the earliest in the next cycle, in IDLE.
// CONFIGURATION
//  INTDIV_CTRL_ABORT_EN defined: adds input abort (1 bit).
//  - abort=1 in LOAD, FEED or DRAIN: next cycle state=IDLE, dp_en=0, digits=00, no out_valid.
//  - abort is ignored in IDLE and DONE.
//  INTDIV_CTRL_ABORT_EN undefined: no abort port. Every accepted operation completes.
// TESTING
//  Datapath model: the bench drives q_digit from a behavioural SD2 divider model with N=8, DELTA=2.
//  1. Unsigned 100/7 -> out_valid exactly 12 cycles after accept, quotient=0x0E, div_by_zero=0.
//  2. Signed -100/7 -> first x_digit=00 then 11 at bit 6; quotient=0xF2.
//  3. Divisor 0, dividend 0x55 -> out_valid 2 cycles after accept, quotient=0xFF, div_by_zero=1, dp_en never 1.
//  4. Signed 0x80/0xFF -> quotient=0x80, div_by_zero=0.
//  5. out_ready low for 5 cycles in DONE, in_valid pulsed -> quotient stable, in_ready=0, pulse ignored.
//     Then out_ready=1 -> in_ready=1 next cycle.
//  6. rst_n low on the 3rd FEED cycle -> dp_en=0 and in_ready=1 asynchronously.
//     The next op (20/3) yields 0x06.
//  7. (ABORT_EN) abort on the 4th FEED cycle -> IDLE next cycle, no out_valid.
//     The next op (9/3) yields 0x03.

Source files
------------

// File: rtl/intdiv_seq_ctrl.sv
// Operand/digit sequencer for the digit-serial SD2 integer divider datapath.
// Optional abort input is compiled in when INTDIV_CTRL_ABORT_EN is defined.
module intdiv_seq_ctrl #(
  parameter int N     = 16,
  parameter int DELTA = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         is_signed,
`ifdef INTDIV_CTRL_ABORT_EN
  input  logic         abort,
`endif
  output logic         dp_clr,
  output logic         dp_en,
  output logic [1:0]   x_digit,
  output logic [1:0]   d_digit,
  input  logic [1:0]   q_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         div_by_zero
);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;

  localparam int CW = $clog2(N + DELTA + 1);
  localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N + DELTA - 1);
  localparam logic [CW-1:0] DELTA_C    = CW'(DELTA);

  state_t        state, next_state;
  logic [CW-1:0] cnt, it_q;
  logic [N-1:0]  x_sh, d_sh, q_acc, q_val;
  logic [N-1:0]  x_mag_in, d_mag_in;
  logic          x_sign, d_sign, dbz, fresh_dz;
  logic          abort_i, accept, div_zero_in;
  logic          dp_clr_d, dp_en_d, out_valid_d;
  logic [1:0]    x_digit_d, d_digit_d;

`ifdef INTDIV_CTRL_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  function automatic logic [1:0] sd2(input logic mag_bit, input logic neg);
    return mag_bit ? (neg ? 2'b11 : 2'b01) : 2'b00;
  endfunction

  assign accept      = in_valid && (state == IDLE);
  assign div_zero_in = (divisor == '0);
  assign x_mag_in    = (is_signed && dividend[N-1]) ? -dividend : dividend;
  assign d_mag_in    = (is_signed && divisor[N-1])  ? -divisor  : divisor;
  assign quotient    = q_acc;
  assign div_by_zero = dbz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = div_zero_in ? DONE : LOAD;
      LOAD:    next_state = FEED;
      FEED:    if (cnt == FEED_LAST) next_state = DRAIN;
      DRAIN:   if (cnt == DRAIN_LAST) next_state = DONE;
      DONE:    if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort_i && (state == LOAD || state == FEED || state == DRAIN))
      next_state = IDLE;
  end

  // A divide-by-zero result waits one DONE cycle so it surfaces two cycles after accept.
  always_comb begin
    in_ready    = (state == IDLE);
    dp_clr_d    = (state == LOAD) && !abort_i;
    dp_en_d     = (state == FEED || state == DRAIN) && !abort_i;
    x_digit_d   = 2'b00;
    d_digit_d   = 2'b00;
    if (state == FEED && !abort_i) begin
      x_digit_d = sd2(x_sh[N-1], x_sign);
      d_digit_d = sd2(d_sh[N-1], d_sign);
    end
    out_valid_d = (state == DONE) && !fresh_dz && !(out_valid && out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_clr    <= 1'b0;
      dp_en     <= 1'b0;
      x_digit   <= 2'b00;
      d_digit   <= 2'b00;
      out_valid <= 1'b0;
    end else begin
      dp_clr    <= dp_clr_d;
      dp_en     <= dp_en_d;
      x_digit   <= x_digit_d;
      d_digit   <= d_digit_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    case (q_digit)
      2'b01:   q_val = {{(N-1){1'b0}}, 1'b1};
      2'b11:   q_val = '1;
      default: q_val = '0;
    endcase
  end

  // it_q tracks the iteration that the registered dp_en/digits belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      it_q     <= '0;
      x_sh     <= '0;
      d_sh     <= '0;
      x_sign   <= 1'b0;
      d_sign   <= 1'b0;
      q_acc    <= '0;
      dbz      <= 1'b0;
      fresh_dz <= 1'b0;
    end else begin
      it_q <= cnt;
      if (accept) begin
        x_sh     <= x_mag_in;
        d_sh     <= d_mag_in;
        x_sign   <= is_signed & dividend[N-1];
        d_sign   <= is_signed & divisor[N-1];
        dbz      <= div_zero_in;
        fresh_dz <= div_zero_in;
        if (div_zero_in) q_acc <= '1;
      end else begin
        fresh_dz <= 1'b0;
      end
      if (state == LOAD) begin
        cnt   <= '0;
        q_acc <= '0;
      end else if (state == FEED || state == DRAIN) begin
        cnt <= cnt + 1'b1;
      end
      if (state == FEED) begin
        x_sh <= x_sh << 1;
        d_sh <= d_sh << 1;
      end
      if (dp_en && it_q >= DELTA_C)
        q_acc <= {q_acc[N-2:0], 1'b0} + q_val;
    end
  end

endmodule
